// File: rtl/trace_request_queue.sv
// In-order trace request queue that holds each record until simulated CPU time reaches its timestamp.
// Optional macro TRACE_QUEUE_TIME_SKIP_EN: an idle CPU clock jumps straight to a pending head's timestamp.
module trace_request_queue #(
    parameter int MEM_ADDR_WIDTH = 64,
    parameter int CPU_CLK_WIDTH  = 32,
    parameter int CPU_CORE_WIDTH = 4,
    parameter int MEM_OPN_WIDTH  = 3,
    parameter int QUEUE_DEPTH    = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             time_en,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [CPU_CLK_WIDTH-1:0]         in_time,
    input  logic [CPU_CORE_WIDTH-1:0]        in_core,
    input  logic [MEM_OPN_WIDTH-1:0]         in_opn,
    input  logic [MEM_ADDR_WIDTH-1:0]        in_addr,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [CPU_CLK_WIDTH-1:0]         out_time,
    output logic [CPU_CORE_WIDTH-1:0]        out_core,
    output logic [MEM_OPN_WIDTH-1:0]         out_opn,
    output logic [MEM_ADDR_WIDTH-1:0]        out_addr,
    output logic [CPU_CLK_WIDTH-1:0]         cpu_time,
    output logic [$clog2(QUEUE_DEPTH):0]     count,
    output logic                             full,
    output logic                             empty,
    output logic                             err_opn,
    output logic                             err_order
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [CPU_CLK_WIDTH-1:0]  ts;
        logic [CPU_CORE_WIDTH-1:0] core;
        logic [MEM_OPN_WIDTH-1:0]  opn;
        logic [MEM_ADDR_WIDTH-1:0] addr;
    } rec_t;

    rec_t                     mem [QUEUE_DEPTH];
    rec_t                     head;
    rec_t                     in_rec;
    logic [PTR_W-1:0]         wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]         count_reg, count_next;
    logic [CPU_CLK_WIDTH-1:0] cpu_time_reg, cpu_time_next;
    logic [CPU_CLK_WIDTH-1:0] last_time_reg;
    logic [CPU_CLK_WIDTH-1:0] head_diff, order_diff;
    logic                     err_opn_reg, err_order_reg;
    logic                     push, store, pop, legal, eligible;

    assign in_rec     = '{ts: in_time, core: in_core, opn: in_opn, addr: in_addr};
    assign head       = mem[rd_ptr_reg];
    assign empty      = (count_reg == '0);
    assign full       = (count_reg == CNT_W'(QUEUE_DEPTH));
    assign in_ready   = !full;

    // Wrap-safe time compares: the MSB of the modular difference is the sign.
    assign head_diff  = cpu_time_reg - head.ts;
    assign order_diff = in_time - last_time_reg;
    assign eligible   = !head_diff[CPU_CLK_WIDTH-1];

    assign legal      = (in_opn <= MEM_OPN_WIDTH'(2));
    assign push       = in_valid && in_ready;
    assign store      = push && legal;
    assign out_valid  = !empty && eligible;
    assign pop        = out_valid && out_ready;

    assign out_time   = head.ts;
    assign out_core   = head.core;
    assign out_opn    = head.opn;
    assign out_addr   = head.addr;
    assign cpu_time   = cpu_time_reg;
    assign count      = count_reg;
    assign err_opn    = err_opn_reg;
    assign err_order  = err_order_reg;

    always_comb begin
        count_next = count_reg;
        if (store && !pop)
            count_next = count_reg + CNT_W'(1);
        else if (pop && !store)
            count_next = count_reg - CNT_W'(1);
    end

    always_comb begin
        cpu_time_next = cpu_time_reg;
        if (time_en) begin
`ifdef TRACE_QUEUE_TIME_SKIP_EN
            if (!empty && !eligible)
                cpu_time_next = head.ts;
            else
                cpu_time_next = cpu_time_reg + CPU_CLK_WIDTH'(1);
`else
            cpu_time_next = cpu_time_reg + CPU_CLK_WIDTH'(1);
`endif
        end
    end

    // Storage entries are plain flops so the head fields read as zero straight out of reset.
    generate
        for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    mem[gi] <= '0;
                else if (store && (wr_ptr_reg == PTR_W'(gi)))
                    mem[gi] <= in_rec;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            cpu_time_reg  <= '0;
            last_time_reg <= '0;
            err_opn_reg   <= 1'b0;
            err_order_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            cpu_time_reg <= cpu_time_next;
            if (store) begin
                wr_ptr_reg    <= wr_ptr_reg + PTR_W'(1);
                last_time_reg <= in_time;
                if (order_diff[CPU_CLK_WIDTH-1])
                    err_order_reg <= 1'b1;
            end
            if (push && !legal)
                err_opn_reg <= 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        end
    end
endmodule
